li_shell_input_queue: RTL and testbench

Sink-end terminator for an `li_link` latency-insensitive channel. It sits between the last relay station of a channel and the pearl (the IP core) inside a shell. It absorbs tokens from `in_link`, buffers them in a `DEPTH`-entry FIFO, and presents them to the pearl through a valid/ready port. Back-pressure to the relay-station chain goes through a registered `in_link.stop`.

---
 rtl/li_pkg.sv | 12 +
 rtl/li_link_if.sv | 14 +
 rtl/li_fifo_storage.sv | 43 ++++
 rtl/li_shell_input_queue.sv | 88 ++++++++
 tb/tb_li_shell_input_queue.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/li_pkg.sv
// Shared definitions for li_link channel blocks: occupancy sizing and the token layout.
// LI_TOKEN_T(W) expands to the {valid, data} token struct for a payload width W.
`define LI_TOKEN_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package li_pkg;

    // Bits needed to count 0..depth stored tokens.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/li_link_if.sv
// li_link latency-insensitive channel: data/valid travel downstream, stop travels upstream.
// A token transfers on an edge where valid=1 and stop=0; stop is never a function of valid.
interface li_link #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             stop;

    modport source (output data, output valid, input stop);
    modport sink   (input data, input valid, output stop);
    modport master (output data, output valid, input stop);
    modport slave  (input data, input valid, output stop);
endinterface

// File: rtl/li_fifo_storage.sv
// DEPTH x WIDTH token storage with wrapping write/read pointers and a head read port.
module li_fifo_storage #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/li_shell_input_queue.sv
// Sink-end terminator of an li_link channel: buffers tokens and offers them to the pearl.
// Optional same-cycle bypass into an empty queue: define LI_SHELL_INPUT_BYPASS_EN.
module li_shell_input_queue
    import li_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    li_link.sink                        in_link,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [occ_width(DEPTH)-1:0] occupancy
);
    localparam int CW = occ_width(DEPTH);

    if (DEPTH < 2) begin : g_depth_check
        $fatal(1, "li_shell_input_queue: DEPTH must be at least 2");
    end

    typedef `LI_TOKEN_T(WIDTH) token_t;

    token_t           in_tok;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             stop_q;
    logic             enq;
    logic             head_valid;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;

    assign in_tok     = '{valid: in_link.valid, data: in_link.data};
    assign enq        = in_tok.valid && !stop_q;
    assign head_valid = (count != '0);

`ifdef LI_SHELL_INPUT_BYPASS_EN
    logic byp;
    // Bypass only when empty, so a bypassed token can never overtake a stored one.
    assign byp       = !head_valid && enq;
    assign out_valid = head_valid || byp;
    assign out_data  = byp ? in_tok.data : rd_data;
    assign wr_en     = enq && !(byp && out_ready);
    assign rd_en     = head_valid && out_ready;
`else
    assign out_valid = head_valid;
    assign out_data  = rd_data;
    assign wr_en     = enq;
    assign rd_en     = head_valid && out_ready;
`endif

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // stop is registered from the post-edge count; this keeps out_ready off the stop path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            stop_q <= 1'b0;
        end else begin
            count  <= count_next;
            stop_q <= (count_next == CW'(DEPTH));
        end
    end

    li_fifo_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (in_tok.data),
        .rd_en   (rd_en),
        .rd_data (rd_data)
    );

    assign in_link.stop = stop_q;
    assign occupancy    = count;
endmodule

// File: tb/tb_li_shell_input_queue.sv
// Self-checking bench for li_shell_input_queue (WIDTH=6, DEPTH=4): vector table plus
// streaming, random and reset sequences; bypass check when LI_SHELL_INPUT_BYPASS_EN is set.
module tb_li_shell_input_queue;
    localparam int W = 6;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic [2:0]   occupancy;

    li_link #(.WIDTH(W)) link ();

    li_shell_input_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_link   (link),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        link.valid = v;
        link.data  = d;
        out_ready  = r;
    endtask

    // One cycle through the scoreboard: inputs set, outputs sampled, then the edge.
    task automatic sb_cycle(input logic v, input logic [W-1:0] d, input logic r, output logic popped);
        logic [W-1:0] exp_d;
        drive(v, d, r);
        #1;
        popped = 1'b0;
        if (v && !link.stop) exp_q.push_back(d);
        if (out_valid && r) begin
            popped = 1'b1;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_d = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(exp_d));
            end
        end
        @(posedge clk);
        #1;
        chk("sb_occ", 32'(occupancy), 32'(exp_q.size()));
        if (occupancy > 3'(D)) chk("sb_occ_bound", 32'(occupancy), 32'(D));
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic [2:0]   occ;
        logic         ov;
        logic         od_care;
        logic [W-1:0] od;
        logic         stop;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic v, logic [W-1:0] d, logic r, logic [2:0] occ,
                                logic ov, logic od_care, logic [W-1:0] od, logic stop);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.occ = occ; t.ov = ov;
        t.od_care = od_care; t.od = od; t.stop = stop;
        return t;
    endfunction

    initial begin
        logic popped;
        int   pops;
        // Idle after reset, fill to full, blocked 5th token, single pulse dequeue, drain.
        tbl[0]  = mk(0, 6'h00, 0, 0, 0, 1, 6'h00, 0);
        tbl[1]  = mk(0, 6'h00, 1, 0, 0, 1, 6'h00, 0);
        tbl[2]  = mk(0, 6'h00, 0, 0, 0, 1, 6'h00, 0);
        tbl[3]  = mk(1, 6'h01, 0, 1, 1, 1, 6'h01, 0);
        tbl[4]  = mk(1, 6'h02, 0, 2, 1, 1, 6'h01, 0);
        tbl[5]  = mk(1, 6'h03, 0, 3, 1, 1, 6'h01, 0);
        tbl[6]  = mk(1, 6'h04, 0, 4, 1, 1, 6'h01, 1);
        tbl[7]  = mk(1, 6'h05, 0, 4, 1, 1, 6'h01, 1);
        tbl[8]  = mk(1, 6'h05, 1, 3, 1, 1, 6'h02, 0);
        tbl[9]  = mk(1, 6'h05, 0, 4, 1, 1, 6'h02, 1);
        tbl[10] = mk(0, 6'h00, 1, 3, 1, 1, 6'h03, 0);
        tbl[11] = mk(0, 6'h00, 1, 2, 1, 1, 6'h04, 0);
        tbl[12] = mk(0, 6'h00, 1, 1, 1, 1, 6'h05, 0);
        tbl[13] = mk(0, 6'h00, 1, 0, 0, 0, 6'h00, 0);

        drive(0, '0, 0);
        reset = 1'b0;
        #1;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_stop", 32'(link.stop), 0);
        chk("rst_data", 32'(out_data), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_stop", i), 32'(link.stop), 32'(tbl[i].stop));
            if (tbl[i].od_care) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].od));
        end
        drive(0, '0, 0);

        // Streaming 0x00..0x3F with out_ready held high.
        pops = 0;
        for (int i = 0; i < 65; i++) begin
            sb_cycle(i < 64, 6'(i), 1'b1, popped);
            if (popped) pops++;
            chk("stream_stop", 32'(link.stop), 0);
        end
        chk("stream_pops", 32'(pops), 64);
        chk("stream_empty", 32'(exp_q.size()), 0);

        // Random traffic including void tokens.
        for (int i = 0; i < 400; i++) begin
            sb_cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 3) != 0 || i > 380), popped);
        end
        drive(0, '0, 1);
        for (int i = 0; i < 6; i++) sb_cycle(1'b0, '0, 1'b1, popped);
        chk("rand_empty", 32'(occupancy), 0);

        // Asynchronous reset with three tokens stored.
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1, 6'h30 + 6'(i), 0);
            @(posedge clk);
        end
        #1 drive(0, '0, 0);
        chk("pre_rst_occ", 32'(occupancy), 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_occ", 32'(occupancy), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_stop", 32'(link.stop), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_occ", 32'(occupancy), 0);
        chk("post_rst_valid", 32'(out_valid), 0);
        drive(1, 6'h11, 0);
        @(posedge clk);
        #1 drive(0, '0, 0);
        chk("post_rst_occ1", 32'(occupancy), 1);
        chk("post_rst_head", 32'(out_data), 32'h11);
        drive(0, '0, 1);
        @(posedge clk);
        #1 drive(0, '0, 0);
        chk("post_rst_drain", 32'(occupancy), 0);
        chk("post_rst_novalid", 32'(out_valid), 0);

`ifdef LI_SHELL_INPUT_BYPASS_EN
        drive(1, 6'h2A, 1);
        #1;
        chk("byp_valid", 32'(out_valid), 1);
        chk("byp_data", 32'(out_data), 32'h2A);
        @(posedge clk);
        #1 drive(0, '0, 0);
        chk("byp_occ", 32'(occupancy), 0);
        chk("byp_after_valid", 32'(out_valid), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
